lenet_argmax_stage: RTL and testbench

- Classification stage directly downstream of the Lenet_accelerator output layer.
- Consumes the 10 signed class scores as a serial valid/ready stream, one score per handshake.
- Tracks the running maximum and emits a registered result: class index, winning score and a one-hot LED pattern.
- Replaces the combinational argmax at the top level with a pipelined, reset-clean, back-pressured block.

---
 rtl/lenet_pkg.sv | 31 +++
 rtl/lenet_argmax_stage.sv | 104 ++++++++++
 tb/tb_lenet_argmax_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// lenet_pkg: shared widths, types and helpers for the LeNet classification stages.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

package lenet_pkg;

  localparam int top_bitwidth = 9;
  localparam int NUM_CLASSES  = 10;
  localparam int CLASS_W      = $clog2(NUM_CLASSES);

  typedef logic signed [top_bitwidth-1:0] score_t;
  typedef logic [CLASS_W-1:0]             class_t;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_CLASSES-1:0] onehot_class(input class_t c);
    logic [NUM_CLASSES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (c == class_t'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lenet_argmax_stage.sv
// lenet_argmax_stage: streaming argmax over one frame of signed class scores.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module lenet_argmax_stage
  import lenet_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           score_valid,
  output logic                           score_ready,
  input  logic signed [top_bitwidth-1:0] score_data,
  input  logic                           score_last,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [CLASS_W-1:0]             result_class,
  output logic signed [top_bitwidth-1:0] result_score,
  output logic [NUM_CLASSES-1:0]         led,
  output logic                           frame_error
);

  state_t r_state;
  state_t w_state_nxt;

  class_t r_count;
  score_t r_max;
  class_t r_idx;

  logic   w_hs;
  logic   w_last_slot;
  logic   w_frame_end;
  logic   w_take;
  score_t w_max_nxt;
  class_t w_idx_nxt;

  // Handshake derived from state, not from score_ready, to keep the FSM loop-free.
  assign w_hs        = score_valid && (r_state == SCAN);
  assign w_last_slot = (r_count == class_t'(NUM_CLASSES - 1));
  assign w_frame_end = w_hs && (score_last || w_last_slot);

  // First score of a frame always seeds; later ones win only on strictly greater.
  assign w_take    = (r_count == '0) || (score_data > r_max);
  assign w_max_nxt = w_take ? score_data : r_max;
  assign w_idx_nxt = w_take ? r_count    : r_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    score_ready  = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      SCAN: begin
        score_ready = 1'b1;
        if (w_frame_end) w_state_nxt = HOLD;
      end
      HOLD: begin
        result_valid = 1'b1;
        if (result_ready) w_state_nxt = SCAN;
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_max        <= '0;
      r_idx        <= '0;
      result_class <= '0;
      result_score <= '0;
      led          <= '0;
      frame_error  <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (w_hs) begin
        if (w_frame_end) begin
          result_class <= w_idx_nxt;
          result_score <= w_max_nxt;
          r_count      <= '0;
          // Short frame (early last) or long frame (no last in final slot).
          frame_error  <= score_last ^ w_last_slot;
        end else begin
          r_max   <= w_max_nxt;
          r_idx   <= w_idx_nxt;
          r_count <= r_count + class_t'(1);
        end
      end
      if ((r_state == HOLD) && result_ready) begin
        led <= onehot_class(result_class);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lenet_argmax_stage.sv
// tb_lenet_argmax_stage: table-driven and randomized checks of the argmax stage.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module tb_lenet_argmax_stage;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              score_valid;
  logic              score_ready;
  logic signed [8:0] score_data;
  logic              score_last;
  logic              result_valid;
  logic              result_ready;
  logic [3:0]        result_class;
  logic signed [8:0] result_score;
  logic [9:0]        led;
  logic              frame_error;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_led;

  typedef struct {
    string name;
    int    n;
    bit    last;
    int    s[10];
    int    hold;
    int    exp_class;
    int    exp_score;
    int    exp_err;
  } frame_vec_t;

  frame_vec_t vecs[7];

  lenet_argmax_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .score_valid  (score_valid),
    .score_ready  (score_ready),
    .score_data   (score_data),
    .score_last   (score_last),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score),
    .led          (led),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: find the largest value, then the first position holding it.
  task automatic ref_argmax(input int s[10], input int n, output int c, output int m);
    m = s[0];
    for (int i = 1; i < n; i++) if (s[i] > m) m = s[i];
    c = -1;
    for (int i = n - 1; i >= 0; i--) if (s[i] == m) c = i;
  endtask

  task automatic send_score(input int d, input logic last, input bit mid);
    int budget = 0;
    score_valid = 1'b1;
    score_data  = 9'(d);
    score_last  = last;
    while (!score_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!score_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got score_ready=0 expected 1");
      score_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    score_valid = 1'b0;
    score_last  = 1'b0;
    if (mid) chk("valid_during_scan", int'(result_valid), 0);
  endtask

  task automatic check_result(input string nm, input int ec, input int es, input int ee,
                              input int hold);
    chk({nm, "_valid"}, int'(result_valid), 1);
    chk({nm, "_class"}, int'(result_class), ec);
    chk({nm, "_score"}, int'(result_score), es);
    chk({nm, "_ferr"},  int'(frame_error), ee);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_ready"}, int'(score_ready), 0);
      chk({nm, "_hold_valid"}, int'(result_valid), 1);
      chk({nm, "_hold_class"}, int'(result_class), ec);
      chk({nm, "_hold_score"}, int'(result_score), es);
      chk({nm, "_hold_led"},   int'(led), int'(exp_led));
      chk({nm, "_hold_ferr"},  int'(frame_error), 0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    exp_led = 10'b1 << ec;
    chk({nm, "_led"},        int'(led), int'(exp_led));
    chk({nm, "_valid_drop"}, int'(result_valid), 0);
    chk({nm, "_ready_back"}, int'(score_ready), 1);
  endtask

  task automatic run_vec(input frame_vec_t v);
    for (int i = 0; i < v.n; i++) begin
      send_score(v.s[i], v.last && (i == v.n - 1), i != v.n - 1);
    end
    check_result(v.name, v.exp_class, v.exp_score, v.exp_err, v.hold);
  endtask

  initial begin
    frame_vec_t rv;
    int rc, rm;
    int rst_frame[10];

    vecs[0] = '{"basic",    10, 1'b1, '{3, -7, 12, 5, 12, 0, -128, 1, 2, 11}, 0, 2, 12, 0};
    vecs[1] = '{"allneg",   10, 1'b1, '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5}, 1, 0, -5, 0};
    vecs[2] = '{"maxlast",  10, 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127}, 5, 9, 127, 0};
    vecs[3] = '{"short",     4, 1'b1, '{1, 9, 4, 2, 0, 0, 0, 0, 0, 0}, 2, 1, 9, 1};
    vecs[4] = '{"aftshort", 10, 1'b1, '{10, 20, -30, 40, -50, 60, 60, -70, 80, -90}, 0, 8, 80, 0};
    vecs[5] = '{"minvals",  10, 1'b1, '{-256, -256, -256, -256, -255, -256, -256, -256, -256, -255}, 1, 4, -255, 0};
    vecs[6] = '{"maxtie",   10, 1'b1, '{255, 0, -1, 254, 3, 3, 3, 3, 3, 255}, 0, 0, 255, 0};

    reset_n      = 1'b0;
    score_valid  = 1'b0;
    score_data   = '0;
    score_last   = 1'b0;
    result_ready = 1'b0;
    exp_led      = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("rst_valid", int'(result_valid), 0);
    chk("rst_class", int'(result_class), 0);
    chk("rst_score", int'(result_score), 0);
    chk("rst_led",   int'(led), 0);
    chk("rst_ferr",  int'(frame_error), 0);
    chk("rst_ready", int'(score_ready), 1);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Long frame: ten scores without last, an eleventh waiting through HOLD.
    for (int i = 0; i < 10; i++) send_score(i == 3 ? 30 : i, 1'b0, i != 9);
    chk("long_ferr",  int'(frame_error), 1);
    chk("long_valid", int'(result_valid), 1);
    chk("long_class", int'(result_class), 3);
    chk("long_score", int'(result_score), 30);
    score_valid = 1'b1;
    score_data  = 9'(50);
    score_last  = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("long_blocked", int'(score_ready), 0);
      chk("long_ferr_once", int'(frame_error), 0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    exp_led = 10'b1 << 3;
    chk("long_led", int'(led), int'(exp_led));
    chk("long_ready_back", int'(score_ready), 1);
    @(posedge clk); #1;
    score_valid = 1'b0;
    for (int i = 0; i < 9; i++) send_score(-i, i == 8, i != 8);
    check_result("long_next", 0, 50, 0, 1);

    // Asynchronous reset partway through a frame.
    for (int i = 0; i < 6; i++) send_score(100, 1'b0, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid", int'(result_valid), 0);
    chk("arst_class", int'(result_class), 0);
    chk("arst_score", int'(result_score), 0);
    chk("arst_led",   int'(led), 0);
    chk("arst_ferr",  int'(frame_error), 0);
    chk("arst_ready", int'(score_ready), 1);
    exp_led = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    rst_frame = '{1, 2, 3, 4, 5, 6, 7, 40, 8, 9};
    for (int i = 0; i < 10; i++) send_score(rst_frame[i], i == 9, i != 9);
    check_result("post_rst", 7, 40, 0, 0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      rv.name = "rand";
      rv.n    = $urandom_range(1, 10);
      rv.last = (rv.n < 10) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 10; i++) rv.s[i] = int'($urandom_range(0, 511)) - 256;
      if ($urandom_range(0, 3) == 0) rv.s[rv.n - 1] = rv.s[0];
      rv.hold = $urandom_range(0, 3);
      ref_argmax(rv.s, rv.n, rc, rm);
      rv.exp_class = rc;
      rv.exp_score = rm;
      rv.exp_err   = ((rv.n < 10) && rv.last) || ((rv.n == 10) && !rv.last) ? 1 : 0;
      run_vec(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
